// File: rtl/ps2_host_tx_if.sv
// Command handshake between the keyboard controller and the PS/2 host transmitter.
//   start : request to send di (master -> slave)
//   di    : command byte, captured when start is accepted (master -> slave)
//   busy  : transfer in progress (slave -> master)
//   done  : one-ce pulse, byte sent and ACKed by the device (slave -> master)
//   error : one-ce pulse, NACK or timeout (slave -> master)
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] di;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output start, di, input busy, done, error);
    modport slave  (input start, di, output busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one command
// byte (LSB first, odd parity, stop) out on device-generated clock falls and checks the ACK.
// Ports:
//   clock   : system clock
//   reset   : asynchronous active-low reset
//   ce      : clock enable; every register update is qualified by it
//   bus     : ps2_host_tx_if.slave (start, di, busy, done, error)
//   ps2CkI  : raw ps2 clock pad level
//   ps2DI   : raw ps2 data pad level
//   ps2CkOe : 1 = pull ps2 clock low
//   ps2DOe  : 1 = pull ps2 data low
// Optional feature macro: PS2TX_RETRY_EN (NACK/timeout retried twice before error).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 840,
    parameter int unsigned TIMEOUT_CYCLES = 140000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ce,
    ps2_host_tx_if.slave bus,
    input  logic         ps2CkI,
    input  logic         ps2DI,
    output logic         ps2CkOe,
    output logic         ps2DOe
);
    localparam int unsigned CNT_W  = 18;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(9);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [9:0]        frame_q, frame_d;
    logic [9:0]        frame_sh_c;
    logic              ck_oe_d, d_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              fail_c, timeout_c;

    logic [1:0]        ck_sync, d_sync;
    logic              ck_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall_c;

`ifdef PS2TX_RETRY_EN
    logic [1:0]        retry_q, retry_d;
`endif

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;

    // Pad synchronisers and clock glitch filter; the filtered level flips only after
    // FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_sync  <= 2'b11;
            d_sync   <= 2'b11;
            ck_filt  <= 1'b1;
            filt_cnt <= '0;
        end else if (ce) begin
            ck_sync <= {ck_sync[0], ps2CkI};
            d_sync  <= {d_sync[0], ps2DI};
            if (ck_sync[1] == ck_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                ck_filt  <= ck_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    // One-ce pulse when the filtered clock is about to flip 1 -> 0.
    assign fall_c = ce & ck_filt & ~ck_sync[1] & (filt_cnt == FILT_LAST);

    assign frame_sh_c = frame_q >> bit_q;

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            ps2CkOe <= 1'b0;
            ps2DOe  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            ps2CkOe <= ck_oe_d;
            ps2DOe  <= d_oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef PS2TX_RETRY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retry_q <= '0;
        end else if (ce) begin
            retry_q <= retry_d;
        end
    end
`endif

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        ck_oe_d   = ps2CkOe;
        d_oe_d    = ps2DOe;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail_c    = 1'b0;
        timeout_c = 1'b0;
`ifdef PS2TX_RETRY_EN
        retry_d   = retry_q;
`endif

        // Device-clocked states share the counter as a saturating no-edge timer.
        if (state_q == SEND || state_q == ACK || state_q == WAITIDLE) begin
            if (fall_c) begin
                cnt_d = '0;
            end else begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                timeout_c = (cnt_q >= TO_LAST);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    frame_d = {1'b1, ~^bus.di, bus.di};
                    cnt_d   = '0;
                    ck_oe_d = 1'b1;
                    state_d = INHIBIT;
`ifdef PS2TX_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            INHIBIT: begin
                ck_oe_d = 1'b1;
                if (cnt_q >= INH_LAST) begin
                    d_oe_d  = 1'b1;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                ck_oe_d = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                // Data changes only on a fall so it is stable for the device's rising sample.
                if (fall_c) begin
                    d_oe_d = ~frame_sh_c[0];
                    if (bit_q == BIT_LAST) state_d = ACK;
                    else                   bit_d   = bit_q + BIT_W'(1);
                end else if (timeout_c) begin
                    fail_c = 1'b1;
                end
            end
            ACK: begin
                if (fall_c) begin
                    if (!d_sync[1]) state_d = WAITIDLE;
                    else            fail_c  = 1'b1;
                end else if (timeout_c) begin
                    fail_c = 1'b1;
                end
            end
            WAITIDLE: begin
                if (ck_filt && d_sync[1]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timeout_c) begin
                    fail_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Failure releases both lines in the same tick.
        if (fail_c) begin
            ck_oe_d = 1'b0;
            d_oe_d  = 1'b0;
`ifdef PS2TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                cnt_d   = '0;
                state_d = INHIBIT;
            end else begin
                error_d = 1'b1;
                state_d = IDLE;
            end
`else
            error_d = 1'b1;
            state_d = IDLE;
`endif
        end

        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TO   = 600;
    localparam int FL   = 4;
    localparam int HALF = 40;   // device clock half period in system clocks
`ifdef PS2TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clock = 1'b0;
    logic reset;
    logic ce;
    logic ps2CkOe, ps2DOe;
    logic dev_ck_low, dev_d_low, glitch;
    logic ps2_ck, ps2_d;
    int   checks = 0;
    int   errors = 0;

    // Open-drain wired-AND of host, device and glitch injector.
    assign ps2_ck = ~(ps2CkOe | dev_ck_low | glitch);
    assign ps2_d  = ~(ps2DOe | dev_d_low);

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .bus    (bus),
        .ps2CkI (ps2_ck),
        .ps2DI  (ps2_d),
        .ps2CkOe(ps2CkOe),
        .ps2DOe (ps2DOe)
    );

    initial forever #5 clock = ~clock;

    // ce high on every other clock, changed away from the active edge.
    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clock);
            ce = ~ce;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    function automatic logic exp_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tick_ce();
        do @(posedge clock); while (ce !== 1'b1);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        bus.di    = b;
        bus.start = 1'b1;
        tick_ce();
        bus.start = 1'b0;
        bus.di    = ~b;
        check("busy_on_accept", 32'(bus.busy), 32'd1);
    endtask

    // Wait for the host inhibit, optionally measure it, then expect the start bit.
    task automatic wait_host_req(input bit measure);
        int n;
        n = 0;
        while (ps2CkOe !== 1'b1 && n < 4 * INH) begin tick_ce(); n++; end
        check("inhibit_seen", 32'(ps2CkOe), 32'd1);
        n = 0;
        while (ps2CkOe === 1'b1 && n < 4 * INH) begin tick_ce(); n++; end
        if (measure) check_range("inhibit_len", n, INH, INH + 2);
        check("start_bit_low", 32'(ps2DOe), 32'd1);
    endtask

    // Device generates 10 clock pulses and samples data just before each rising edge.
    task automatic device_frame(input logic [7:0] b, input int glitch_k, input bit poke,
                                output logic [9:0] rx);
        wait_clk(HALF);
        for (int k = 0; k < 10; k++) begin
            dev_ck_low = 1'b1;
            if (poke && k == 2) begin
                bus.di    = ~b;
                bus.start = 1'b1;
                tick_ce();
                bus.start = 1'b0;
            end
            wait_clk(HALF);
            rx[k]      = ps2_d;
            dev_ck_low = 1'b0;
            if (k == glitch_k) begin
                wait_clk(10);
                glitch = 1'b1;
                wait_clk(6);
                glitch = 1'b0;
                wait_clk(HALF - 16);
            end else begin
                wait_clk(HALF);
            end
        end
    endtask

    // ACK clock pulse; on the final attempt wait for and check the result pulse.
    task automatic ack_phase(input bit nack, input bit final_try);
        bit hit;
        int n;
        dev_d_low = ~nack;
        wait_clk(4);
        dev_ck_low = 1'b1;
        hit = 1'b0;
        n = 0;
        if (final_try) begin
            while (!hit && n < 4 * HALF) begin
                tick_ce();
                n++;
                if (n == HALF / 2)     dev_ck_low = 1'b0;
                if (n == HALF / 2 + 2) dev_d_low  = 1'b0;
                if (bus.done === 1'b1 || bus.error === 1'b1) hit = 1'b1;
            end
            dev_ck_low = 1'b0;
            dev_d_low  = 1'b0;
            check("result_seen", 32'(hit), 32'd1);
            check("done", 32'(bus.done), 32'(!nack));
            check("error", 32'(bus.error), 32'(nack));
            check("busy_at_result", 32'(bus.busy), 32'd0);
            check("lines_released", 32'({ps2CkOe, ps2DOe}), 32'd0);
            tick_ce();
            check("pulse_one_tick", 32'({bus.done, bus.error}), 32'd0);
        end else begin
            repeat (HALF / 2) tick_ce();
            dev_ck_low = 1'b0;
            dev_d_low  = 1'b0;
            check("retry_busy", 32'(bus.busy), 32'd1);
            check("retry_no_error", 32'(bus.error), 32'd0);
        end
    endtask

    task automatic transfer(input logic [7:0] b, input bit nack, input int glitch_k, input bit poke);
        logic [9:0] rx;
        int tries;
        tries = nack ? ATTEMPTS : 1;
        pulse_start(b);
        for (int a = 0; a < tries; a++) begin
            wait_host_req(a == 0);
            device_frame(b, glitch_k, poke, rx);
            check("rx_data", 32'(rx[7:0]), 32'(b));
            check("rx_parity", 32'(rx[8]), 32'(exp_parity(b)));
            check("rx_odd_ones", 32'($countones(rx[8:0]) % 2), 32'd1);
            check("rx_stop", 32'(rx[9]), 32'd1);
            ack_phase(nack, a == tries - 1);
        end
    endtask

    task automatic timeout_test(input logic [7:0] b);
        int n;
        pulse_start(b);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_host_req(a == 0);
            n = 0;
            while (bus.done !== 1'b1 && bus.error !== 1'b1 && ps2CkOe !== 1'b1 && n < TO + 50) begin
                tick_ce();
                n++;
            end
            check_range("timeout_len", n, TO - 1, TO + 1);
            if (a < ATTEMPTS - 1) check("timeout_retry_busy", 32'(bus.busy), 32'd1);
        end
        check("timeout_error", 32'(bus.error), 32'd1);
        check("timeout_no_done", 32'(bus.done), 32'd0);
        check("timeout_busy", 32'(bus.busy), 32'd0);
        check("timeout_lines", 32'({ps2CkOe, ps2DOe}), 32'd0);
        tick_ce();
        check("timeout_pulse_one_tick", 32'(bus.error), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bit seen;

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.di     = 8'h00;
        dev_ck_low = 1'b0;
        dev_d_low  = 1'b0;
        glitch     = 1'b0;
        wait_clk(6);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done_error", 32'({bus.done, bus.error}), 32'd0);
        check("rst_lines", 32'({ps2CkOe, ps2DOe}), 32'd0);
        reset = 1'b1;
        wait_clk(20);

        // Known commands, then odd/even parity corners.
        transfer(8'hED, 1'b0, -1, 1'b0);
        transfer(8'h01, 1'b0, -1, 1'b0);
        transfer(8'hFF, 1'b0, -1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            transfer(b, 1'b0, -1, 1'b0);
        end

        // Device never clocks.
        b = 8'($urandom);
        timeout_test(b);
        wait_clk(20);

        // Device NACKs.
        b = 8'($urandom);
        transfer(b, 1'b1, -1, 1'b0);
        wait_clk(20);

        // Reset in the middle of the frame.
        b = 8'($urandom);
        pulse_start(b);
        wait_host_req(1'b0);
        wait_clk(HALF);
        for (int k = 0; k < 4; k++) begin
            dev_ck_low = 1'b1;
            wait_clk(HALF);
            dev_ck_low = 1'b0;
            wait_clk(HALF);
        end
        dev_ck_low = 1'b1;
        wait_clk(HALF / 2);
        check("busy_mid_send", 32'(bus.busy), 32'd1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_lines", 32'({ps2CkOe, ps2DOe}), 32'd0);
        check("async_rst_done_error", 32'({bus.done, bus.error}), 32'd0);
        dev_ck_low = 1'b0;
        wait_clk(10);
        reset = 1'b1;
        wait_clk(20);
        b = 8'($urandom);
        transfer(b, 1'b0, -1, 1'b0);

        // Start while busy plus a short clock glitch: same frame, no second frame.
        b = 8'($urandom);
        transfer(b, 1'b0, 3, 1'b1);
        seen = 1'b0;
        repeat (2 * INH) begin
            tick_ce();
            if (ps2CkOe === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        check("no_second_frame", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
